// File: rtl/alu_op_sequencer.sv
// Purpose: single-clock front end for the board ALU: debounced opcode stepping and execute sequencing.
// Latency: button edge to press = DB_CYCLES+2 edges; press[2] to valid = ALU_LAT+2 edges.
// Backpressure: none; button presses arriving in LOAD/EXEC are dropped, not queued.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   button[2:0]              raw buttons: [0] mode-1, [1] mode+1, [2] execute
//   sw_a, sw_b               operand switch banks, latched into op_a/op_b in LOAD
//   alu_value, alu_cf/of/zf  combinational ALU result and flags, captured at end of EXEC
//   mode, op_a, op_b, en     drive the ALU
//   result, cf, of, zf       held copy of the last completed operation
//   valid                    result/flags belong to a completed operation
//   state                    IDLE=0, LOAD=1, EXEC=2, DONE=3
//   press[2:0]               one-cycle debounced rising-edge pulses
module alu_op_sequencer #(
  parameter int DB_CYCLES = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] button,
  input  logic [3:0] sw_a,
  input  logic [3:0] sw_b,
  input  logic [3:0] alu_value,
  input  logic       alu_cf,
  input  logic       alu_of,
  input  logic       alu_zf,
  output logic [2:0] mode,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       en,
  output logic [3:0] result,
  output logic       cf,
  output logic       of,
  output logic       zf,
  output logic       valid,
  output logic [1:0] state,
  output logic [2:0] press
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int LW  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [LW-1:0]  LAT_LAST = LW'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Debounce path
  logic [2:0]          sync1_q, sync1_d;
  logic [2:0]          sync2_q, sync2_d;
  logic [2:0]          db_q, db_d;
  logic [2:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic [2:0]          press_q, press_d;

  // Control path
  state_t          state_q, state_d;
  logic [2:0]      mode_q, mode_d;
  logic [3:0]      op_a_q, op_a_d;
  logic [3:0]      op_b_q, op_b_d;
  logic [3:0]      result_q, result_d;
  logic            cf_q, cf_d;
  logic            of_q, of_d;
  logic            zf_q, zf_d;
  logic            valid_q, valid_d;
  logic            en_q, en_d;
  logic [LW-1:0]   exec_cnt_q, exec_cnt_d;

  logic mode_up, mode_dn;

  // Counter tracks consecutive synced samples that disagree with the
  // debounced level; the DB_CYCLES-th disagreeing sample flips the level.
  always_comb begin
    sync1_d  = button;
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    press_d  = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_d[i]     = sync2_q[i];
        db_cnt_d[i] = '0;
        press_d[i]  = sync2_q[i];   // only 0->1 flips pulse
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
      end
    end
  end

  // Simultaneous up and down cancel out.
  assign mode_up = press_q[1] & ~press_q[0];
  assign mode_dn = press_q[0] & ~press_q[1];

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    result_d   = result_q;
    cf_d       = cf_q;
    of_d       = of_q;
    zf_d       = zf_q;
    valid_d    = valid_q;
    exec_cnt_d = exec_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (mode_up) begin
          mode_d = mode_q + 3'd1;
        end else if (mode_dn) begin
          mode_d = mode_q - 3'd1;
        end
        // Execute wins over the DONE->IDLE clear; a coincident mode step
        // still lands, so the new operation runs with the new mode.
        if (press_q[2]) begin
          state_d = S_LOAD;
          valid_d = 1'b0;
        end else if (mode_up || mode_dn) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      S_LOAD: begin
        op_a_d     = sw_a;
        op_b_d     = sw_b;
        exec_cnt_d = '0;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        if (exec_cnt_q == LAT_LAST) begin
          result_d = alu_value;
          cf_d     = alu_cf;
          of_d     = alu_of;
          zf_d     = alu_zf;
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end else begin
          exec_cnt_d = exec_cnt_q + LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered decode of the next state keeps en glitch-free and high
    // for exactly the EXEC cycles.
    en_d = (state_d == S_EXEC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      db_cnt_q   <= '0;
      press_q    <= '0;
      state_q    <= S_IDLE;
      mode_q     <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      result_q   <= '0;
      cf_q       <= 1'b0;
      of_q       <= 1'b0;
      zf_q       <= 1'b0;
      valid_q    <= 1'b0;
      en_q       <= 1'b0;
      exec_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      state_q    <= state_d;
      mode_q     <= mode_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      result_q   <= result_d;
      cf_q       <= cf_d;
      of_q       <= of_d;
      zf_q       <= zf_d;
      valid_q    <= valid_d;
      en_q       <= en_d;
      exec_cnt_q <= exec_cnt_d;
    end
  end

  assign mode   = mode_q;
  assign op_a   = op_a_q;
  assign op_b   = op_b_q;
  assign en     = en_q;
  assign result = result_q;
  assign cf     = cf_q;
  assign of     = of_q;
  assign zf     = zf_q;
  assign valid  = valid_q;
  assign state  = state_q;
  assign press  = press_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose: bench for alu_op_sequencer; three instances with ALU_LAT = 1, 3, 12 share stimulus.
// Latency: outputs compared against a reference model one time unit after every clock edge.
// Backpressure: none; directed button sequences followed by randomized toggling and resets.
module tb_alu_op_sequencer;

  localparam int NI = 3;
  localparam int DB = 4;
  localparam int HN = 16384;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 12;
  endfunction

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] button = '0;
  logic [3:0] sw_a = '0;
  logic [3:0] sw_b = '0;

  always #5 clk = ~clk;

  logic [3:0] alu_value [NI];
  logic       alu_cf [NI], alu_of [NI], alu_zf [NI];
  logic [2:0] mode_o [NI];
  logic [3:0] op_a_o [NI], op_b_o [NI], result_o [NI];
  logic       en_o [NI], cf_o [NI], of_o [NI], zf_o [NI], valid_o [NI];
  logic [1:0] state_o [NI];
  logic [2:0] press_o [NI];

  // Bench ALU: {cf, of, zf, value}; mode 0 is a plain add.
  function automatic logic [6:0] alu_fn(input logic [2:0] m, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] v;
    s = {1'b0, a} + {1'b0, b} + {2'b00, m};
    v = s[3:0];
    return {s[4], v[3] ^ a[3], (v == 4'd0), v};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign {alu_cf[g], alu_of[g], alu_zf[g], alu_value[g]} = alu_fn(mode_o[g], op_a_o[g], op_b_o[g]);

    alu_op_sequencer #(
      .DB_CYCLES (DB),
      .ALU_LAT   ((g == 0) ? 1 : (g == 1) ? 3 : 12)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .button    (button),
      .sw_a      (sw_a),
      .sw_b      (sw_b),
      .alu_value (alu_value[g]),
      .alu_cf    (alu_cf[g]),
      .alu_of    (alu_of[g]),
      .alu_zf    (alu_zf[g]),
      .mode      (mode_o[g]),
      .op_a      (op_a_o[g]),
      .op_b      (op_b_o[g]),
      .en        (en_o[g]),
      .result    (result_o[g]),
      .cf        (cf_o[g]),
      .of        (of_o[g]),
      .zf        (zf_o[g]),
      .valid     (valid_o[g]),
      .state     (state_o[g]),
      .press     (press_o[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // age = edges since execute was accepted (-1 when not busy):
  // 0 -> LOAD, 1..lat -> EXEC, reaching lat+1 captures the result.
  logic [2:0] m_mode [NI];
  logic [3:0] m_a [NI], m_b [NI], m_res [NI];
  logic       m_cf [NI], m_of [NI], m_zf [NI], m_valid [NI];
  int         m_age [NI];
  logic [2:0] m_press [NI], m_db [NI], m_r1 [NI], m_r2 [NI];
  int         m_streak [NI][3];

  task automatic model_step(input int i);
    logic       up, dn, smp;
    logic [6:0] r;
    logic [2:0] np;
    if (rst) begin
      m_mode[i] = '0; m_a[i] = '0; m_b[i] = '0; m_res[i] = '0;
      m_cf[i] = 1'b0; m_of[i] = 1'b0; m_zf[i] = 1'b0; m_valid[i] = 1'b0;
      m_age[i] = -1;
      m_press[i] = '0; m_db[i] = '0; m_r1[i] = '0; m_r2[i] = '0;
      for (int b = 0; b < 3; b++) m_streak[i][b] = 0;
    end else begin
      up = m_press[i][1] && !m_press[i][0];
      dn = m_press[i][0] && !m_press[i][1];
      if (m_age[i] < 0) begin
        if (up) m_mode[i] = m_mode[i] + 3'd1;
        else if (dn) m_mode[i] = m_mode[i] - 3'd1;
        if (m_press[i][2]) begin
          m_age[i] = 0;
          m_valid[i] = 1'b0;
        end else if (up || dn) begin
          m_valid[i] = 1'b0;
        end
      end else begin
        m_age[i]++;
        if (m_age[i] == 1) begin
          m_a[i] = sw_a;
          m_b[i] = sw_b;
        end
        if (m_age[i] == lat_of(i) + 1) begin
          r = alu_fn(m_mode[i], m_a[i], m_b[i]);
          {m_cf[i], m_of[i], m_zf[i], m_res[i]} = r;
          m_valid[i] = 1'b1;
          m_age[i] = -1;
        end
      end
      // A button's level is accepted once DB consecutive samples (seen two
      // edges late through the synchronizer) disagree with the current level.
      np = '0;
      for (int b = 0; b < 3; b++) begin
        smp = m_r2[i][b];
        if (smp != m_db[i][b]) m_streak[i][b]++;
        else m_streak[i][b] = 0;
        if (m_streak[i][b] == DB) begin
          m_db[i][b] = smp;
          m_streak[i][b] = 0;
          np[b] = smp;
        end
      end
      m_r2[i] = m_r1[i];
      m_r1[i] = button;
      m_press[i] = np;
    end
  endtask

  function automatic logic [1:0] m_state(input int i);
    if (m_age[i] < 0) return m_valid[i] ? 2'd3 : 2'd0;
    return (m_age[i] == 0) ? 2'd1 : 2'd2;
  endfunction

  // hist[i][edge] = {0, press[2:0], valid, en, state[1:0]}
  int         edge_no = 0;
  logic [7:0] hist [NI][HN];

  always @(posedge clk) begin
    #1;
    edge_no++;
    for (int i = 0; i < NI; i++) begin
      model_step(i);
      chk($sformatf("mode[%0d]", i), 16'(mode_o[i]), 16'(m_mode[i]));
      chk($sformatf("ops[%0d]", i), 16'({op_a_o[i], op_b_o[i]}), 16'({m_a[i], m_b[i]}));
      chk($sformatf("state[%0d]", i), 16'(state_o[i]), 16'(m_state(i)));
      chk($sformatf("en[%0d]", i), 16'(en_o[i]), 16'(m_state(i) == 2'd2));
      chk($sformatf("valid[%0d]", i), 16'(valid_o[i]), 16'(m_valid[i]));
      chk($sformatf("res[%0d]", i), 16'({cf_o[i], of_o[i], zf_o[i], result_o[i]}),
          16'({m_cf[i], m_of[i], m_zf[i], m_res[i]}));
      chk($sformatf("press[%0d]", i), 16'(press_o[i]), 16'(m_press[i]));
      if (edge_no < HN) hist[i][edge_no] = {1'b0, press_o[i], valid_o[i], en_o[i], state_o[i]};
    end
  end

  function automatic int find_press(input int i, input int b, input int from, input int to);
    for (int e = from; e <= to && e < HN; e++) if (hist[i][e][4+b]) return e;
    return -1;
  endfunction

  function automatic int count_press(input int i, input int b, input int from, input int to);
    int n = 0;
    for (int e = from; e <= to && e < HN; e++) if (hist[i][e][4+b]) n++;
    return n;
  endfunction

  function automatic int count_state(input int i, input logic [1:0] st, input int from, input int to);
    int n = 0;
    for (int e = from; e <= to && e < HN; e++) if (hist[i][e][1:0] == st) n++;
    return n;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int b);
    button[b] = 1'b1;
    cyc(8);
    button[b] = 1'b0;
    cyc(10);
  endtask

  initial begin
    int e0, e1, p, n;
    logic [6:0] r;

    // Reset with random inputs
    rst = 1'b1;
    repeat (3) begin
      button = 3'($urandom); sw_a = 4'($urandom); sw_b = 4'($urandom);
      @(negedge clk);
    end
    for (int i = 0; i < NI; i++) begin
      chk("rst_outs", 16'({mode_o[i], en_o[i], valid_o[i], state_o[i], press_o[i]}), 16'h0);
      chk("rst_data", 16'({op_a_o[i], op_b_o[i], result_o[i], cf_o[i], of_o[i], zf_o[i]}), 16'h0);
    end
    rst = 1'b0; button = '0; sw_a = '0; sw_b = '0;
    cyc(10);

    // Glitch of 3 samples is rejected
    e0 = edge_no;
    button[1] = 1'b1; cyc(3); button[1] = 1'b0; cyc(12);
    chk("glitch_press", 16'(count_press(0, 1, e0, edge_no)), 16'd0);
    chk("glitch_mode", 16'(mode_o[0]), 16'd0);

    // Long hold: one pulse, DB+1 edges after the first high sample
    e0 = edge_no;
    button[1] = 1'b1; cyc(20);
    p = find_press(0, 1, e0, edge_no);
    chk("db_latency", 16'(p - (e0 + 1)), 16'(DB + 1));
    e1 = edge_no;
    button[1] = 1'b0; cyc(12);
    chk("hold_count", 16'(count_press(0, 1, e0, edge_no)), 16'd1);
    chk("release_press", 16'(count_press(0, 1, e1 + 1, edge_no)), 16'd0);
    chk("hold_mode", 16'(mode_o[0]), 16'd1);

    // Wrap and simultaneous presses
    push(0);
    chk("dn_to0", 16'(mode_o[0]), 16'd0);
    push(0);
    chk("wrap_dn", 16'(mode_o[0]), 16'd7);
    push(1);
    chk("wrap_up", 16'(mode_o[0]), 16'd0);
    button = 3'b011; cyc(8); button = '0; cyc(10);
    chk("both_mode", 16'(mode_o[0]), 16'd0);

    // Execute, ALU_LAT=1
    sw_a = 4'b0011; sw_b = 4'b0010;
    e0 = edge_no;
    push(2);
    cyc(5);
    p = find_press(0, 2, e0, edge_no);
    if (p < 0) begin
      chk("ex_press_seen", 16'd0, 16'd1);
    end else begin
      chk("ex_load", 16'(hist[0][p+1][2:0]), 16'b001);
      chk("ex_exec", 16'(hist[0][p+2][2:0]), 16'b110);
      chk("ex_done", 16'(hist[0][p+3][3:0]), 16'b1011);
    end
    chk("ex_op_a", 16'(op_a_o[0]), 16'd3);
    chk("ex_op_b", 16'(op_b_o[0]), 16'd2);
    chk("ex_result", 16'(result_o[0]), 16'd5);
    chk("ex_flags", 16'({cf_o[0], of_o[0], zf_o[0]}), 16'd0);
    chk("ex_valid", 16'(valid_o[0]), 16'd1);
    sw_a = 4'hC; cyc(5);
    chk("sw_hold_op_a", 16'(op_a_o[0]), 16'd3);
    chk("sw_hold_res", 16'(result_o[0]), 16'd5);

    // Mode press lands in EXEC for lat 3/12 (dropped) and in DONE for lat 1 (clears)
    sw_a = 4'd5; sw_b = 4'd1;
    e0 = edge_no;
    button[2] = 1'b1; cyc(3);
    button[1] = 1'b1; cyc(1);
    button[2] = 1'b0; cyc(3);
    button[1] = 1'b0; cyc(20);
    r = alu_fn(3'd0, 4'd5, 4'd1);
    chk("lock_mode1", 16'(mode_o[1]), 16'd0);
    chk("lock_exec1", 16'(count_state(1, 2'd2, e0, edge_no)), 16'd3);
    chk("lock_done1", 16'({valid_o[1], state_o[1]}), 16'b111);
    chk("lock_res1", 16'(result_o[1]), 16'(r[3:0]));
    chk("lock_mode2", 16'(mode_o[2]), 16'd0);
    chk("lock_exec2", 16'(count_state(2, 2'd2, e0, edge_no)), 16'd12);
    chk("clr_mode0", 16'(mode_o[0]), 16'd1);
    chk("clr_vs0", 16'({valid_o[0], state_o[0]}), 16'b000);
    chk("clr_keep_res0", 16'(result_o[0]), 16'(r[3:0]));

    // Second execute press during lat-12 EXEC; re-execute from DONE for lat 1/3
    sw_a = 4'd7; sw_b = 4'd1;
    e0 = edge_no;
    button[2] = 1'b1; cyc(4);
    button[2] = 1'b0; cyc(4);
    sw_a = 4'd2;
    button[2] = 1'b1; cyc(4);
    button[2] = 1'b0; cyc(30);
    chk("relock_loads2", 16'(count_state(2, 2'd1, e0, edge_no)), 16'd1);
    r = alu_fn(3'd0, 4'd7, 4'd1);
    chk("relock_res2", 16'(result_o[2]), 16'(r[3:0]));
    chk("reex_loads0", 16'(count_state(0, 2'd1, e0, edge_no)), 16'd2);
    p = find_press(0, 2, e0 + 10, edge_no);
    if (p < 0) begin
      chk("reex_press_seen", 16'd0, 16'd1);
    end else begin
      chk("reex_v0_drop", 16'({hist[0][p][3], hist[0][p+1][3]}), 16'b10);
      chk("reex_v0_pre", 16'(hist[0][p+2][3]), 16'd0);
      chk("reex_v0_set", 16'(hist[0][p+3][3]), 16'd1);
      chk("reex_v1_pre", 16'(hist[1][p+4][3]), 16'd0);
      chk("reex_v1_set", 16'(hist[1][p+5][3]), 16'd1);
    end
    r = alu_fn(3'd1, 4'd2, 4'd1);
    chk("reex_res0", 16'(result_o[0]), 16'(r[3:0]));
    r = alu_fn(3'd0, 4'd2, 4'd1);
    chk("reex_res1", 16'(result_o[1]), 16'(r[3:0]));

    // Reset mid-EXEC, button held through reset release
    button[2] = 1'b1;
    n = 0;
    while (state_o[2] != 2'd2 && n < 40) begin
      cyc(1);
      n++;
    end
    chk("wait_exec", 16'(state_o[2]), 16'd2);
    rst = 1'b1; cyc(1); rst = 1'b0;
    for (int i = 0; i < NI; i++)
      chk("midrst", 16'({state_o[i], en_o[i], valid_o[i], mode_o[i]}), 16'd0);
    e0 = edge_no;
    cyc(12);
    chk("held_rst_press", 16'(count_press(0, 2, e0 + 1, edge_no)), 16'd1);
    button = '0;
    cyc(20);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 5) == 0) button[b] = ~button[b];
      if ($urandom_range(0, 3) == 0) sw_a = 4'($urandom);
      if ($urandom_range(0, 3) == 0) sw_b = 4'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0; button = '0;
    cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
